// File: rtl/mantissa_aligner.sv
// Pre-add alignment: picks the larger-exponent operand and right-shifts the
// smaller mantissa by the exponent difference, STEP bits per cycle, keeping G/R/S.
//
// state   | meaning
// IDLE    | waiting for an operand pair, in_ready=1
// COMPARE | pick larger operand, compute exponent difference
// SHIFT   | shift smaller mantissa right, at most STEP bits per cycle
// DONE    | aligned result held until out_ready
module mantissa_aligner #(
  parameter int MANTISSA_N = 24,
  parameter int EXP_N      = 8,
  parameter int STEP       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    a_sign,
  input  logic [EXP_N-1:0]        a_exp,
  input  logic [MANTISSA_N-1:0]   a_mant,
  input  logic                    b_sign,
  input  logic [EXP_N-1:0]        b_exp,
  input  logic [MANTISSA_N-1:0]   b_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_N-1:0]        out_exp,
  output logic                    out_sign_l,
  output logic                    out_sign_s,
  output logic [MANTISSA_N+2:0]   out_mant_l,
  output logic [MANTISSA_N+2:0]   out_mant_s,
  output logic                    out_swapped
);

  localparam int W = MANTISSA_N + 3;

  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    a_sign_q, a_sign_d, b_sign_q, b_sign_d;
  logic [EXP_N-1:0]        a_exp_q, a_exp_d, b_exp_q, b_exp_d;
  logic [MANTISSA_N-1:0]   a_mant_q, a_mant_d, b_mant_q, b_mant_d;
  logic [EXP_N-1:0]        exp_q, exp_d, rem_q, rem_d;
  logic                    sign_l_q, sign_l_d, sign_s_q, sign_s_d;
  logic                    swapped_q, swapped_d;
  logic [W-1:0]            mant_l_q, mant_l_d, ext_q, ext_d;

  logic [EXP_N-1:0]        exp_l, exp_s, diff, sh;
  logic [MANTISSA_N-1:0]   mant_l_c, mant_s_c;
  logic                    lost;

  always_comb begin
    state_d   = state_q;
    a_sign_d  = a_sign_q;
    a_exp_d   = a_exp_q;
    a_mant_d  = a_mant_q;
    b_sign_d  = b_sign_q;
    b_exp_d   = b_exp_q;
    b_mant_d  = b_mant_q;
    exp_d     = exp_q;
    rem_d     = rem_q;
    sign_l_d  = sign_l_q;
    sign_s_d  = sign_s_q;
    swapped_d = swapped_q;
    mant_l_d  = mant_l_q;
    ext_d     = ext_q;
    exp_l     = a_exp_q;
    exp_s     = b_exp_q;
    mant_l_c  = a_mant_q;
    mant_s_c  = b_mant_q;
    diff      = '0;
    sh        = '0;
    lost      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sign_d = a_sign;
          a_exp_d  = a_exp;
          a_mant_d = a_mant;
          b_sign_d = b_sign;
          b_exp_d  = b_exp;
          b_mant_d = b_mant;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        // ties keep A as the larger operand
        if (a_exp_q >= b_exp_q) begin
          sign_l_d  = a_sign_q;
          sign_s_d  = b_sign_q;
          swapped_d = 1'b0;
        end else begin
          exp_l     = b_exp_q;
          exp_s     = a_exp_q;
          mant_l_c  = b_mant_q;
          mant_s_c  = a_mant_q;
          sign_l_d  = b_sign_q;
          sign_s_d  = a_sign_q;
          swapped_d = 1'b1;
        end
        diff     = exp_l - exp_s;
        exp_d    = exp_l;
        mant_l_d = {mant_l_c, 3'b000};
        ext_d    = {mant_s_c, 3'b000};
        if (32'(diff) >= 32'(W)) begin
          ext_d   = W'(|mant_s_c);
          state_d = DONE;
        end else if (diff == '0) begin
          state_d = DONE;
        end else begin
          rem_d   = diff;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sh    = (rem_q > EXP_N'(STEP)) ? EXP_N'(STEP) : rem_q;
        lost  = |(ext_q & ~({W{1'b1}} << sh));
        ext_d = (ext_q >> sh) | W'(lost);
        rem_d = rem_q - sh;
        if (rem_q == sh) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sign_q  <= 1'b0;
      a_exp_q   <= '0;
      a_mant_q  <= '0;
      b_sign_q  <= 1'b0;
      b_exp_q   <= '0;
      b_mant_q  <= '0;
      exp_q     <= '0;
      rem_q     <= '0;
      sign_l_q  <= 1'b0;
      sign_s_q  <= 1'b0;
      swapped_q <= 1'b0;
      mant_l_q  <= '0;
      ext_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sign_q  <= a_sign_d;
      a_exp_q   <= a_exp_d;
      a_mant_q  <= a_mant_d;
      b_sign_q  <= b_sign_d;
      b_exp_q   <= b_exp_d;
      b_mant_q  <= b_mant_d;
      exp_q     <= exp_d;
      rem_q     <= rem_d;
      sign_l_q  <= sign_l_d;
      sign_s_q  <= sign_s_d;
      swapped_q <= swapped_d;
      mant_l_q  <= mant_l_d;
      ext_q     <= ext_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_exp     = exp_q;
  assign out_sign_l  = sign_l_q;
  assign out_sign_s  = sign_s_q;
  assign out_mant_l  = mant_l_q;
  assign out_mant_s  = ext_q;
  assign out_swapped = swapped_q;

endmodule

// File: tb/tb_mantissa_aligner.sv
// Randomized + directed bench for mantissa_aligner against an arithmetic
// reference model of the alignment (single shift with sticky OR).
module tb_mantissa_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        a_sign, b_sign, out_sign_l, out_sign_s, out_swapped;
  logic [7:0]  a_exp, b_exp, out_exp;
  logic [23:0] a_mant, b_mant;
  logic [26:0] out_mant_l, out_mant_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mantissa_aligner #(.MANTISSA_N(24), .EXP_N(8), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_exp(a_exp), .a_mant(a_mant),
    .b_sign(b_sign), .b_exp(b_exp), .b_mant(b_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_exp(out_exp), .out_sign_l(out_sign_l), .out_sign_s(out_sign_s),
    .out_mant_l(out_mant_l), .out_mant_s(out_mant_s), .out_swapped(out_swapped)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Alignment as one wide shift: kept bits, plus sticky if anything nonzero fell off.
  task automatic model(input logic as_, input logic [7:0] ae, input logic [23:0] am,
                       input logic bs_, input logic [7:0] be, input logic [23:0] bm,
                       output longint e_exp, output longint e_ml, output longint e_ms,
                       output longint e_sw, output longint e_sl, output longint e_ss,
                       output int e_lat);
    int     diff;
    longint ms, full;
    e_sw  = (be > ae) ? 1 : 0;
    e_exp = e_sw ? be : ae;
    e_ml  = (e_sw ? longint'(bm) : longint'(am)) * 8;
    ms    = e_sw ? longint'(am) : longint'(bm);
    e_sl  = e_sw ? bs_ : as_;
    e_ss  = e_sw ? as_ : bs_;
    diff  = e_sw ? (int'(be) - int'(ae)) : (int'(ae) - int'(be));
    full  = ms * 8;
    if (diff >= 27) begin
      e_ms  = (ms != 0) ? 1 : 0;
      e_lat = 2;
    end else begin
      e_ms = full >> diff;
      if ((full % (longint'(1) << diff)) != 0) e_ms = e_ms | 1;
      e_lat = (diff == 0) ? 2 : 2 + (diff + 3) / 4;
    end
  endtask

  task automatic do_op(input logic as_, input logic [7:0] ae, input logic [23:0] am,
                       input logic bs_, input logic [7:0] be, input logic [23:0] bm,
                       input int hold);
    longint e_exp, e_ml, e_ms, e_sw, e_sl, e_ss;
    int     e_lat, lat, n;
    logic [26:0] snap_ml, snap_ms;
    logic [10:0] snap_misc;
    model(as_, ae, am, bs_, be, bm, e_exp, e_ml, e_ms, e_sw, e_sl, e_ss, e_lat);
    @(negedge clk);
    a_sign = as_; a_exp = ae; a_mant = am;
    b_sign = bs_; b_exp = be; b_mant = bm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 64);
    chk("latency", lat, e_lat);
    chk("out_exp", out_exp, e_exp);
    chk("out_mant_l", out_mant_l, e_ml);
    chk("out_mant_s", out_mant_s, e_ms);
    chk("out_swapped", out_swapped, e_sw);
    chk("out_sign_l", out_sign_l, e_sl);
    chk("out_sign_s", out_sign_s, e_ss);
    snap_ml   = out_mant_l;
    snap_ms   = out_mant_s;
    snap_misc = {out_exp, out_sign_l, out_sign_s, out_swapped};
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a_exp  = 8'($urandom); b_exp  = 8'($urandom);
      a_mant = 24'($urandom); b_mant = 24'($urandom);
      @(negedge clk);
      chk("hold_mant_l", out_mant_l, snap_ml);
      chk("hold_mant_s", out_mant_s, snap_ms);
      chk("hold_misc", {out_exp, out_sign_l, out_sign_s, out_swapped}, snap_misc);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    int d;
    logic [7:0] ae, be;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_sign = 1'b0; a_exp = '0; a_mant = '0;
    b_sign = 1'b0; b_exp = '0; b_mant = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_mant_s", out_mant_s, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(1'b0, 8'h80, 24'hC00000, 1'b1, 8'h80, 24'h800000, 0);
    chk("eq_mant_l", out_mant_l, 64'h6000000);
    chk("eq_mant_s", out_mant_s, 64'h4000000);
    chk("eq_sign_s", out_sign_s, 1);
    do_op(1'b0, 8'h7E, 24'h800000, 1'b0, 8'h83, 24'hFFFFFF, 0);
    chk("d5_mant_l", out_mant_l, 64'h7FFFFF8);
    chk("d5_mant_s", out_mant_s, 64'h0200000);
    chk("d5_swapped", out_swapped, 1);
    do_op(1'b0, 8'h80, 24'h800001, 1'b0, 8'h84, 24'h800000, 0);
    chk("sticky_mant_s", out_mant_s, 64'h0400001);
    do_op(1'b0, 8'h28, 24'h800000, 1'b0, 8'h50, 24'h800000, 0);
    chk("huge_mant_s", out_mant_s, 64'h1);
    do_op(1'b0, 8'h28, 24'h000000, 1'b0, 8'h50, 24'h800000, 0);
    chk("huge_zero_mant_s", out_mant_s, 64'h0);
    do_op(1'b1, 8'h90, 24'h9ABCDE, 1'b0, 8'h8B, 24'hF0000F, 5);

    // reset while the diff=5 case is mid-SHIFT
    @(negedge clk);
    a_sign = 1'b0; a_exp = 8'h7E; a_mant = 24'h800000;
    b_sign = 1'b0; b_exp = 8'h83; b_mant = 24'hFFFFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_exp", out_exp, 0);
    chk("mid_rst_out_mant_l", out_mant_l, 0);
    chk("mid_rst_out_mant_s", out_mant_s, 0);
    chk("mid_rst_swapped", out_swapped, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 8'h80, 24'hC00000, 1'b1, 8'h80, 24'h800000, 0);

    for (int k = 0; k < 150; k++) begin
      ae = 8'($urandom_range(40, 215));
      d  = int'($urandom_range(0, 70)) - 35;
      be = 8'(int'(ae) + d);
      if (k % 10 == 3) be = 8'($urandom);
      do_op(1'($urandom), ae, ($urandom_range(0, 7) == 0) ? 24'h0 : 24'($urandom),
            1'($urandom), be, 24'($urandom), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mantissa_aligner.md
Name: mantissa_aligner

Overview:
- Pre-add alignment stage of the floating-point adder; the counterpart of the post-add normalizer.
- Accepts two unpacked operands (sign, biased exponent, mantissa with hidden bit) and selects the larger-exponent operand.
- Right-shifts the smaller operand's mantissa by the exponent difference over multiple cycles, keeping guard/round/sticky bits.
- Presents both aligned mantissas and the common exponent to the adder core over a valid/ready handshake.

Parameters:
- MANTISSA_N, 24, mantissa width including hidden bit.
- EXP_N, 8, biased exponent width (unsigned).
- STEP, 4, maximum right-shift per SHIFT cycle (1..MANTISSA_N+3).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands.
- a_sign  input  1  operand A sign.
- a_exp  input  EXP_N  operand A biased exponent.
- a_mant  input  MANTISSA_N  operand A mantissa.
- b_sign, b_exp, b_mant  input  1/EXP_N/MANTISSA_N  operand B fields.
- out_valid  output  1  aligned result present.
- out_ready  input  1  consumer accepts result.
- out_exp  output  EXP_N  larger exponent (common exponent).
- out_sign_l  output  1  sign of larger operand.
- out_sign_s  output  1  sign of smaller operand.
- out_mant_l  output  MANTISSA_N+3  {larger mantissa, 3'b000}.
- out_mant_s  output  MANTISSA_N+3  {aligned smaller mantissa, guard, round, sticky}.
- out_swapped  output  1  1 when B was selected as larger.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all registered outputs and internal registers 0; out_valid=0.
  - in_ready is decoded from state, so it reads 1 during and after reset.
  - Reset mid-operation discards the operation with no output.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at a rising edge: capture all a_*/b_* fields, go to COMPARE.
- COMPARE (1 cycle):
  - If a_exp >= b_exp (unsigned): large=A, small=B, swapped=0. Tie selects A.
  - Otherwise large=B, small=A, swapped=1.
  - diff = exp_l - exp_s (EXP_N bits, never negative).
  - Load ext = {mant_s, 3'b000}.
  - If diff >= MANTISSA_N+3: ext = {0..0, |mant_s} (all bits collapse into sticky); go to DONE.
  - Else if diff == 0: go to DONE.
  - Else: remaining=diff; go to SHIFT.
- SHIFT:
  - Each cycle sh = min(remaining, STEP).
  - ext = (ext >> sh), with new LSB = old ext[0] | OR of all bits shifted out.
  - remaining -= sh. When remaining becomes 0, go to DONE.
- DONE:
  - out_valid=1. All out_* are stable and unchanged while out_valid & !out_ready.
  - On out_ready: go to IDLE, deassert out_valid.
- in_ready=0 in COMPARE, SHIFT and DONE. in_valid outside IDLE is ignored, not queued.
- Latency, counted from the accept edge to the first edge at which out_valid=1: 2 + ceil(diff/STEP) cycles when 0 < diff < MANTISSA_N+3; otherwise 2.
- Throughput: one operation in flight. Next accept no earlier than the cycle after the out handshake.
- No rounding, sign resolution or special-value (NaN/Inf/denormal) handling here; exponent values pass through unmodified.

Test Plan (MANTISSA_N=24, EXP_N=8, STEP=4):
- Equal exponents: A={0,0x80,0xC00000}, B={1,0x80,0x800000}
  - out_exp=0x80, out_mant_l=0x6000000, out_mant_s=0x4000000, out_swapped=0, out_sign_s=1.
  - out_valid 2 cycles after accept.
- B larger, diff=5: A={0,0x7E,0x800000}, B={0,0x83,0xFFFFFF}
  - out_swapped=1, out_exp=0x83, out_mant_l=0x7FFFFF8, out_mant_s=0x0200000.
  - Latency 4.
- Sticky capture, diff=4: A={0,0x80,0x800001}, B={0,0x84,0x800000}
  - out_mant_s=0x0400001 (sticky=1).
  - Latency 3.
- Huge difference, diff=40: A exp 0x28, mant 0x800000; B exp 0x50
  - out_mant_s=0x0000001, latency 2.
  - Repeat with small mant 0: out_mant_s=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands
  - Outputs bit-stable, in_ready=0, new operands not captured.
  - On out_ready=1: IDLE next cycle, in_ready=1.
- Reset mid-SHIFT: assert rst_n=0 during the diff=5 case
  - Immediately out_valid=0 and outputs 0; in_ready=1.
  - After release, a fresh equal-exponent op completes in 2 cycles.
